// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter with a terminal-count pulse.
// Counts a loaded value down on enabled cycles and then either stops in DONE
// or reloads (periodic mode).
// Optional feature macro: DOWN_COUNTER_TIMER_PRESCALE_EN. When it is defined,
// an internal prescaler makes each decrement take PRESCALE enabled cycles.
module down_counter_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_mode;
    logic             r_busy;
    logic             r_done;
    logic             r_tc;

    logic             w_accept;
    logic             w_run_en;
    logic             w_step;

    // A load can be taken in IDLE or DONE; held low while in reset.
    assign load_ready = reset_n && (r_state != ST_RUN);
    assign w_accept   = load_valid && load_ready;
    assign w_run_en   = (r_state == ST_RUN) && enable;

`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] r_presc;
    logic          w_tick;

    assign w_tick = (r_presc == PW'(PRESCALE - 1));
    assign w_step = w_run_en && w_tick;

    // Prescaler: counts enabled RUN cycles, wraps at PRESCALE-1, restarts on load/abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (abort || w_accept) begin
            r_presc <= '0;
        end else if (w_run_en) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
    end
`else
    // Without the prescaler every enabled RUN cycle is a step.
    assign w_step = w_run_en;

    // PRESCALE has no effect in this build; this empty block only references it.
    if (PRESCALE < 0) begin : g_presc_unused
    end
`endif

    // Main FSM: abort beats load, load beats stepping; all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_mode   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
                r_count <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else if (w_accept) begin
                r_count  <= load_value;
                r_reload <= load_value;
                r_mode   <= auto_reload;
                if (load_value != '0) begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                end else begin
                    // A zero load terminates immediately.
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_tc    <= 1'b1;
                end
            end else if (w_step) begin
                if (r_count == WIDTH'(1)) begin
                    r_tc <= 1'b1;
                    if (r_mode) begin
                        r_count <= r_reload;
                    end else begin
                        r_count <= '0;
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end else begin
                    r_count <= r_count - WIDTH'(1);
                end
            end
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;
    assign tc    = r_tc;

endmodule
